hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline stall/flush controller for the 5-stage MIPS core. Detects load-use hazards that forwarding cannot cover, data-memory wait states, instruction-fetch misses, EX-stage control redirects and halt. It drives the enable/flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches, so it directly controls what the ID/EX latch presents to the forwarding logic. It also keeps saturating performance counters and a data-memory watchdog.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.
- MAX_WAIT, 255, number of consecutive dmem stall cycles after which mem_timeout is set.

Ports. One clock; reset is synchronous and active-high.
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IF_rs  in  5  rs of the instruction in the IF/ID latch.
- IF_rt  in  5  rt of the instruction in the IF/ID latch.
- IF_uses_rt  in  1  that instruction reads rt.
- EX_wsel  in  5  destination register of the instruction in ID/EX.
- EX_MemRead  in  1  instruction in ID/EX is a load.
- EX_redirect  in  1  branch taken or jump resolved in EX.
- MEM_dREN  in  1  read request from the MEM stage.
- MEM_dWEN  in  1  write request from the MEM stage.
- dhit  in  1  data memory done.
- ihit  in  1  instruction memory done.
- WB_halt  in  1  halt instruction in WB.
- pc_en  out  1  PC enable.
- ifid_en  out  1  IF/ID latch enable.
- ifid_flush  out  1  IF/ID latch flush.
- idex_en  out  1  ID/EX latch enable.
- idex_flush  out  1  ID/EX latch flush.
- exmem_en  out  1  EX/MEM latch enable.
- exmem_flush  out  1  EX/MEM latch flush.
- memwb_en  out  1  MEM/WB latch enable.
- memwb_flush  out  1  MEM/WB latch flush.
- halt  out  1  sticky halt.
- mem_timeout  out  1  sticky watchdog error.
- lu_stalls  out  CNT_W  count of load-use bubbles.
- mem_stalls  out  CNT_W  count of dmem wait cycles.
- redirects  out  CNT_W  count of redirect flushes.

## Operation
Internal terms:
- dstall = (MEM_dREN | MEM_dWEN) & ~dhit.
- lu = EX_MemRead & (EX_wsel != 0) & ((EX_wsel == IF_rs) | (IF_uses_rt & (EX_wsel == IF_rt))).

State machine: RUN, DWAIT, HALTED.
- RUN → HALTED when WB_halt is high. This takes priority over all other transitions.
- RUN → DWAIT when dstall is high.
- DWAIT → RUN when dstall is low.
- DWAIT → HALTED when WB_halt is high.
- HALTED is left only by RST.

Output priority, highest first. Every output not named in a row is en=1, flush=0.
1. RST high or state HALTED: all en=0, all flush=0.
2. dstall: pc, ifid, idex and exmem en=0; memwb_flush=1. A bubble enters WB and no double writeback occurs.
3. EX_redirect: pc_en=1, ifid_flush=1, idex_flush=1. Wrong-path instructions are killed. This overrides lu and ~ihit.
4. lu: pc_en=0, ifid_en=0, idex_flush=1. This inserts one bubble and overrides ~ihit.
5. ~ihit: pc_en=0, ifid_flush=1. Later stages advance.

Counters:
- lu_stalls increments in each cycle where row 4 is the active row.
- mem_stalls increments in each cycle where row 2 is active.
- redirects increments in each cycle where row 3 is active.
- All counters saturate at all-ones and do not wrap.
- Counters freeze in HALTED.

Watchdog: wait_cnt (8+ bits, sized for MAX_WAIT) counts consecutive dstall cycles and clears when dstall is low. When wait_cnt reaches MAX_WAIT, mem_timeout is set and stays set until RST. The pipeline stays frozen; the watchdog only reports.

halt is registered: it is set on the edge after WB_halt is seen in RUN or DWAIT.

## Timing
- Reset values: state RUN, halt 0, mem_timeout 0, all counters 0, wait_cnt 0.
- While RST is high, the en/flush outputs follow row 1.
- en/flush outputs are combinational from the inputs and the current state, with zero latency, and valid in the same cycle as the hazard.
- Counters, state, halt and mem_timeout update on the rising edge and are visible the next cycle.
- A load-use hazard produces exactly one bubble. On the next cycle the load is in MEM, so lu is false and forwarding covers the dependency.
- dstall and EX_redirect in the same cycle: the freeze holds EX, so the redirect is still asserted when dhit arrives. Row 3 then applies in that cycle, and redirects counts it once.
- RST asserted during DWAIT: returns to RUN on the next edge, with counters and wait_cnt cleared.

## Test plan
- EX_MemRead=1, EX_wsel=5, IF_rs=5, ihit=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1; lu_stalls=1 next cycle. Repeat with EX_wsel=0 -> no stall.
- MEM_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> freeze for 3 cycles with memwb_flush=1; mem_stalls=3; state returns to RUN.
- EX_redirect=1 together with lu=1 and ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1; redirects=1; lu_stalls unchanged.
- MAX_WAIT=4, dstall held for 6 cycles -> mem_timeout rises after the 4th cycle and remains 1 after dhit; cleared only by RST.
- WB_halt pulse -> halt=1 next cycle; all en=0 thereafter; counters frozen; RST restores the reset values.
- Force a counter to all-ones (CNT_W=4, 16 lu events) -> lu_stalls holds at 15.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard controller port bundle: hazard inputs from the pipeline
// stages, latch enable/flush controls and counter read-outs back to them.
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IF_rs;
    logic [4:0]       IF_rt;
    logic             IF_uses_rt;
    logic [4:0]       EX_wsel;
    logic             EX_MemRead;
    logic             EX_redirect;
    logic             MEM_dREN;
    logic             MEM_dWEN;
    logic             dhit;
    logic             ihit;
    logic             WB_halt;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             memwb_flush;
    logic             halt;
    logic             mem_timeout;
    logic [CNT_W-1:0] lu_stalls;
    logic [CNT_W-1:0] mem_stalls;
    logic [CNT_W-1:0] redirects;

    modport master (
        output IF_rs, IF_rt, IF_uses_rt, EX_wsel, EX_MemRead,
        output EX_redirect, MEM_dREN, MEM_dWEN, dhit, ihit, WB_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        input  exmem_en, exmem_flush, memwb_en, memwb_flush,
        input  halt, mem_timeout, lu_stalls, mem_stalls, redirects
    );

    modport slave (
        input  IF_rs, IF_rt, IF_uses_rt, EX_wsel, EX_MemRead,
        input  EX_redirect, MEM_dREN, MEM_dWEN, dhit, ihit, WB_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        output exmem_en, exmem_flush, memwb_en, memwb_flush,
        output halt, mem_timeout, lu_stalls, mem_stalls, redirects
    );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage core: load-use, dmem wait,
// imem miss, EX redirect and halt, plus perf counters and dmem watchdog.
module hazard_unit #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 255
) (
    input logic         CLK,
    input logic         RST,
    hazard_unit_if.slave hz
);
    localparam int WR = $clog2(MAX_WAIT + 1);
    localparam int WW = (WR < 8) ? 8 : WR;
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

    state_t  state;
    state_t  state_nxt;
    logic    [WW-1:0] wait_cnt;
    logic    [WW-1:0] wait_nxt;
    logic    dstall;
    logic    lu;
    logic    active;
    logic    ms_inc;
    logic    rd_inc;
    logic    lu_inc;

    assign dstall = (hz.MEM_dREN | hz.MEM_dWEN) & ~hz.dhit;
    assign lu = hz.EX_MemRead & (hz.EX_wsel != 5'd0) &
                ((hz.EX_wsel == hz.IF_rs) |
                 (hz.IF_uses_rt & (hz.EX_wsel == hz.IF_rt)));
    assign active = ~RST & (state != HALTED);

    // Row selection mirrors the output priority so counters match it
    assign ms_inc = active & dstall;
    assign rd_inc = active & ~dstall & hz.EX_redirect;
    assign lu_inc = active & ~dstall & ~hz.EX_redirect & lu;

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (hz.WB_halt)  state_nxt = HALTED;
                else if (dstall) state_nxt = DWAIT;
            end
            DWAIT: begin
                if (hz.WB_halt)  state_nxt = HALTED;
                else if (!dstall) state_nxt = RUN;
            end
            default: state_nxt = HALTED;
        endcase
    end

    always_comb begin
        hz.pc_en       = 1'b1;
        hz.ifid_en     = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_en     = 1'b1;
        hz.idex_flush  = 1'b0;
        hz.exmem_en    = 1'b1;
        hz.exmem_flush = 1'b0;
        hz.memwb_en    = 1'b1;
        hz.memwb_flush = 1'b0;
        priority case (1'b1)
            !active: begin
                hz.pc_en    = 1'b0;
                hz.ifid_en  = 1'b0;
                hz.idex_en  = 1'b0;
                hz.exmem_en = 1'b0;
                hz.memwb_en = 1'b0;
            end
            dstall: begin
                hz.pc_en       = 1'b0;
                hz.ifid_en     = 1'b0;
                hz.idex_en     = 1'b0;
                hz.exmem_en    = 1'b0;
                hz.memwb_flush = 1'b1;
            end
            hz.EX_redirect: begin
                hz.ifid_flush = 1'b1;
                hz.idex_flush = 1'b1;
            end
            lu: begin
                hz.pc_en      = 1'b0;
                hz.ifid_en    = 1'b0;
                hz.idex_flush = 1'b1;
            end
            !hz.ihit: begin
                hz.pc_en      = 1'b0;
                hz.ifid_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        wait_nxt = '0;
        if (dstall)
            wait_nxt = (wait_cnt == WMAX) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= RUN;
            hz.halt        <= 1'b0;
            hz.mem_timeout <= 1'b0;
            hz.lu_stalls   <= '0;
            hz.mem_stalls  <= '0;
            hz.redirects   <= '0;
            wait_cnt       <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state != HALTED && hz.WB_halt)
                hz.halt <= 1'b1;
            if (wait_nxt == WMAX)
                hz.mem_timeout <= 1'b1;
            if (lu_inc && hz.lu_stalls != '1)
                hz.lu_stalls <= hz.lu_stalls + 1'b1;
            if (ms_inc && hz.mem_stalls != '1)
                hz.mem_stalls <= hz.mem_stalls + 1'b1;
            if (rd_inc && hz.redirects != '1)
                hz.redirects <= hz.redirects + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed vectors push expected
// controls/registers, a negedge monitor pops and compares.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(4)) hif ();

    hazard_unit #(.CNT_W(4), .MAX_WAIT(4)) dut (
        .CLK(clk),
        .RST(rst),
        .hz (hif)
    );

    typedef struct packed {
        logic [8:0] ctl;
        logic       h;
        logic       t;
        logic [3:0] l;
        logic [3:0] m;
        logic [3:0] r;
    } exp_t;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    //  exmem_en, exmem_flush, memwb_en, memwb_flush}
    localparam logic [8:0] ZERO = 9'b000000000;
    localparam logic [8:0] NORM = 9'b110101010;
    localparam logic [8:0] DST  = 9'b000000011;
    localparam logic [8:0] RED  = 9'b111111010;
    localparam logic [8:0] LU   = 9'b000111010;
    localparam logic [8:0] IMIS = 9'b011101010;

    exp_t  q[$];
    string qn[$];
    int    total = 0;
    int    bad = 0;

    logic       e_h = 1'b0;
    logic       e_t = 1'b0;
    logic [3:0] e_l = '0;
    logic [3:0] e_m = '0;
    logic [3:0] e_r = '0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = q.pop_front();
            n = qn.pop_front();
            a.ctl = {hif.pc_en, hif.ifid_en, hif.ifid_flush,
                     hif.idex_en, hif.idex_flush, hif.exmem_en,
                     hif.exmem_flush, hif.memwb_en, hif.memwb_flush};
            a.h = hif.halt;
            a.t = hif.mem_timeout;
            a.l = hif.lu_stalls;
            a.m = hif.mem_stalls;
            a.r = hif.redirects;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got ctl=%b h=%b t=%b lu=%0d ms=%0d rd=%0d want ctl=%b h=%b t=%b lu=%0d ms=%0d rd=%0d",
                         n, a.ctl, a.h, a.t, a.l, a.m, a.r,
                         e.ctl, e.h, e.t, e.l, e.m, e.r);
            end
        end
    end

    task automatic drv(input logic r, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt,
                       input logic [4:0] ws, input logic mr,
                       input logic red, input logic dr,
                       input logic dh, input logic ih,
                       input logic wh);
        @(posedge clk);
        #1;
        rst            = r;
        hif.IF_rs      = rs;
        hif.IF_rt      = rt;
        hif.IF_uses_rt = urt;
        hif.EX_wsel    = ws;
        hif.EX_MemRead = mr;
        hif.EX_redirect = red;
        hif.MEM_dREN   = dr;
        hif.MEM_dWEN   = 1'b0;
        hif.dhit       = dh;
        hif.ihit       = ih;
        hif.WB_halt    = wh;
    endtask

    task automatic ex(input logic [8:0] c, input string n);
        exp_t e;
        e.ctl = c;
        e.h = e_h;
        e.t = e_t;
        e.l = e_l;
        e.m = e_m;
        e.r = e_r;
        q.push_back(e);
        qn.push_back(n);
    endtask

    task automatic idle(input string n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        ex(NORM, n);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hif.IF_rs = 0; hif.IF_rt = 0; hif.IF_uses_rt = 0;
        hif.EX_wsel = 0; hif.EX_MemRead = 0; hif.EX_redirect = 0;
        hif.MEM_dREN = 0; hif.MEM_dWEN = 0; hif.dhit = 1;
        hif.ihit = 1; hif.WB_halt = 0;

        drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); ex(ZERO, "reset0");
        drv(1, 5, 0, 0, 5, 1, 0, 1, 0, 0, 0); ex(ZERO, "reset_hazards");
        idle("idle");

        drv(0, 5, 0, 0, 5, 1, 0, 0, 1, 1, 0); ex(LU, "lu_rs");
        e_l++;
        idle("after_lu");
        drv(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0); ex(NORM, "lu_r0");
        drv(0, 1, 7, 1, 7, 1, 0, 0, 1, 1, 0); ex(LU, "lu_rt");
        e_l++;
        drv(0, 1, 7, 0, 7, 1, 0, 0, 1, 1, 0); ex(NORM, "rt_unused");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); ex(IMIS, "imiss");

        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); ex(DST, "dstall");
            e_m++;
        end
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); ex(NORM, "dhit");
        idle("after_dstall");

        drv(0, 5, 0, 0, 5, 1, 1, 0, 1, 0, 0); ex(RED, "redir_over_lu");
        e_r++;
        idle("after_redir");

        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0); ex(DST, "dst_redir");
            e_m++;
        end
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0); ex(RED, "redir_at_dhit");
        e_r++;
        idle("after_dst_redir");

        for (int i = 1; i <= 6; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); ex(DST, "wdog");
            e_m++;
            if (i == 4) e_t = 1'b1;
        end
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); ex(NORM, "wdog_dhit");
        idle("wdog_sticky");

        for (int i = 0; i < 16; i++) begin
            drv(0, 3, 0, 0, 3, 1, 0, 0, 1, 1, 0); ex(LU, "lu_sat");
            if (e_l != 4'hF) e_l++;
        end
        idle("lu_sat_hold");

        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); ex(NORM, "wb_halt");
        e_h = 1'b1;
        drv(0, 3, 0, 0, 3, 1, 0, 0, 1, 1, 0); ex(ZERO, "halted_lu");
        drv(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0); ex(ZERO, "halted_dst");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); ex(ZERO, "halted_idle");

        drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); ex(ZERO, "rst_halted");
        e_h = 0; e_t = 0; e_l = 0; e_m = 0; e_r = 0;
        idle("post_rst");

        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); ex(DST, "dwait");
            e_m++;
        end
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); ex(ZERO, "rst_in_dwait");
        e_m = 0;
        idle("post_rst_dwait");
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); ex(DST, "wcnt_cleared");
            e_m++;
        end
        idle("no_timeout");

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
